// File: rtl/expr_eval.sv
// expr_eval: evaluates "digit (op digit)*" ASCII expressions with '+' and '*',
// where '*' binds tighter than '+'. A running value is registered after every
// accepted digit, so it is readable the cycle after that digit is sampled.
// Optional feature macro: EXPR_SAT_EN (clamp overflowing values to all ones
// instead of wrapping modulo 2^W).
module expr_eval #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   input  logic         in_valid,
   output logic [W-1:0] result,
   output logic         result_valid,
   output logic         ovf,
   output logic         err,
   output logic [1:0]   status
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OPD  = 2'b01;
   localparam logic [1:0] OPR  = 2'b10;
   localparam logic [1:0] ERR  = 2'b11;

   logic [1:0]   state, state_nxt;
   logic [W-1:0] sum, term;
   logic         mul;

   logic         is_dig, is_add, is_mul;
   logic [3:0]   dig;
   logic [W+3:0] prod_w, term_new_w, sum_add_w, res_w;
   logic [W-1:0] term_new, sum_add, res_next;
   logic         ovf_dig, ovf_add;

   // True when v does not fit in W bits.
   function automatic logic over(input logic [W+3:0] v);
      return |v[W+3:W];
   endfunction

   // Reduce a wide intermediate to the stored W-bit value.
   function automatic logic [W-1:0] fit(input logic [W+3:0] v);
`ifdef EXPR_SAT_EN
      return over(v) ? {W{1'b1}} : v[W-1:0];
`else
      return v[W-1:0];
`endif
   endfunction

   // Character classification; digits map to their low nibble ('0' is 8'h30).
   always_comb begin
      is_dig = (in >= 8'h30) && (in <= 8'h39);
      is_add = (in == 8'h2B);
      is_mul = (in == 8'h2A);
      dig    = in[3:0];
   end

   // Wide arithmetic for the next term, the '+' fold and the running result.
   always_comb begin
      prod_w     = {4'b0000, term} * {{W{1'b0}}, dig};
      term_new_w = (mul && state == OPR) ? prod_w : {{W{1'b0}}, dig};
      term_new   = fit(term_new_w);
      res_w      = {4'b0000, ((state == IDLE) ? {W{1'b0}} : sum)} + {4'b0000, term_new};
      sum_add_w  = {4'b0000, sum} + {4'b0000, term};
      sum_add    = fit(sum_add_w);
      ovf_dig    = over(term_new_w) || over(res_w);
      ovf_add    = over(sum_add_w);
`ifdef EXPR_SAT_EN
      // Once anything has saturated the result is pinned at full scale until clr.
      res_next   = (ovf || ovf_dig) ? {W{1'b1}} : fit(res_w);
`else
      res_next   = fit(res_w);
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: grammar check on each sampled character.
   always_comb begin
      state_nxt = state;
      if (in_valid) begin
         case (state)
            IDLE:    state_nxt = is_dig ? OPD : ERR;
            OPD:     state_nxt = (is_add || is_mul) ? OPR : ERR;
            OPR:     state_nxt = is_dig ? OPD : ERR;
            default: state_nxt = ERR;
         endcase
      end
   end

   // Output decode from the current state.
   always_comb begin
      status       = state;
      result_valid = (state == OPD);
      err          = (state == ERR);
   end

   // Datapath: sum/term/product flag, registered result and sticky overflow.
   always_ff @(posedge clk) begin
      if (clr) begin
         sum    <= '0;
         term   <= '0;
         mul    <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
      end else if (in_valid) begin
         case (state)
            IDLE: if (is_dig) begin
               sum    <= '0;
               term   <= term_new;
               mul    <= 1'b0;
               result <= res_next;
               ovf    <= ovf | ovf_dig;
            end
            OPD: if (is_add) begin
               sum  <= sum_add;
               term <= '0;
               mul  <= 1'b0;
               ovf  <= ovf | ovf_add;
            end else if (is_mul) begin
               mul  <= 1'b1;
            end
            OPR: if (is_dig) begin
               term   <= term_new;
               result <= res_next;
               ovf    <= ovf | ovf_dig;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval at W=8: fixed vector table, hand-written corner
// sequences, and random character streams checked against an exact-arithmetic
// reference evaluator.
module tb_expr_eval;

   localparam int      W    = 8;
   localparam longint  MAXV = 255;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic [7:0]   in = 8'h00;
   logic         in_valid = 1'b0;
   logic [W-1:0] result;
   logic         result_valid, ovf, err;
   logic [1:0]   status;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   expr_eval #(.W(W)) dut (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .result(result), .result_valid(result_valid),
      .ovf(ovf), .err(err), .status(status)
   );

   // Reference model state: accepted characters since the last clr.
   byte          q[$];
   bit           err_m, ovf_m;
   logic [W-1:0] res_m;

   function automatic bit is_digit(byte c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Exact value of the accepted text: sum of products, '*' before '+'.
   function automatic longint eval_q();
      longint total = 0;
      longint prod  = 0;
      bit     mulp  = 0;
      foreach (q[i]) begin
         if (is_digit(q[i])) begin
            prod = mulp ? prod * longint'(q[i] - 8'h30) : longint'(q[i] - 8'h30);
            mulp = 0;
         end else if (q[i] == "+") begin
            total += prod;
            prod  = 0;
         end else begin
            mulp = 1;
         end
      end
      return total + prod;
   endfunction

   task automatic model_apply(input bit c, input bit v, input byte ch);
      bit     want_d;
      longint val;
      if (c) begin
         q.delete();
         err_m = 0;
         ovf_m = 0;
         res_m = '0;
         return;
      end
      if (!v || err_m) return;
      want_d = (q.size() == 0) || !is_digit(q[$]);
      if ((is_digit(ch) != want_d) || (!is_digit(ch) && ch != "+" && ch != "*")) begin
         err_m = 1;
         return;
      end
      q.push_back(ch);
      if (is_digit(ch)) begin
         val = eval_q();
         if (val > MAXV) ovf_m = 1;
`ifdef EXPR_SAT_EN
         res_m = ovf_m ? {W{1'b1}} : val[W-1:0];
`else
         res_m = val[W-1:0];
`endif
      end
   endtask

   function automatic int exp_status();
      if (err_m) return 3;
      if (q.size() == 0) return 0;
      return is_digit(q[$]) ? 1 : 2;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   task automatic check_model(input string tag);
      int st;
      st = exp_status();
      cmp({tag, " result"}, 32'(result), 32'(res_m));
      cmp({tag, " result_valid"}, 32'(result_valid), 32'(st == 1));
      cmp({tag, " ovf"}, 32'(ovf), 32'(ovf_m));
      cmp({tag, " err"}, 32'(err), 32'(err_m));
      cmp({tag, " status"}, 32'(status), 32'(st));
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic tick(input bit c, input bit v, input byte ch);
      @(negedge clk);
      clr      = c;
      in_valid = v;
      in       = ch;
      @(posedge clk);
      #1;
      model_apply(c, v, ch);
      clr      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input int gap, input string tag);
      for (int i = 0; i < s.len(); i++) begin
         tick(0, 1, s[i]);
         check_model(tag);
         for (int g = 0; g < gap; g++) begin
            tick(0, 0, byte'($urandom_range(0, 255)));
            check_model({tag, " idle"});
         end
      end
   endtask

   typedef struct {
      string s;
      int    gap;
      int    res;
      bit    rv;
      bit    ov;
      bit    er;
      int    st;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int  n_expr;
      int  len;
      byte ch;

      tbl[0]  = '{"1+2*3",     0, 7,   1, 0, 0, 1};
      tbl[1]  = '{"2*3*4+5",   2, 29,  1, 0, 0, 1};
      tbl[2]  = '{"1++2",      0, 1,   0, 0, 1, 3};
`ifdef EXPR_SAT_EN
      tbl[3]  = '{"9*9*9",     0, 255, 1, 1, 0, 1};
      tbl[4]  = '{"9*9*3+9+4", 1, 255, 1, 1, 0, 1};
`else
      tbl[3]  = '{"9*9*9",     0, 217, 1, 1, 0, 1};
      tbl[4]  = '{"9*9*3+9+4", 1, 0,   1, 1, 0, 1};
`endif
      tbl[5]  = '{"9*9*3+9+3", 0, 255, 1, 0, 0, 1};
      tbl[6]  = '{"a",         0, 0,   0, 0, 1, 3};
      tbl[7]  = '{"+",         0, 0,   0, 0, 1, 3};
      tbl[8]  = '{"1+2*",      0, 3,   0, 0, 0, 2};
      tbl[9]  = '{"0",         0, 0,   1, 0, 0, 1};
      tbl[10] = '{"12",        0, 1,   0, 0, 1, 3};
      tbl[11] = '{"8*0+6*7",   1, 42,  1, 0, 0, 1};

      // Reset state.
      tick(1, 0, 8'h00);
      cmp("reset result", 32'(result), 0);
      cmp("reset result_valid", 32'(result_valid), 0);
      cmp("reset ovf", 32'(ovf), 0);
      cmp("reset err", 32'(err), 0);
      cmp("reset status", 32'(status), 0);

      // Table vectors: clr, feed the string, compare final outputs with hand values.
      foreach (tbl[k]) begin
         tick(1, 0, 8'h00);
         send_str(tbl[k].s, tbl[k].gap, {"vec ", tbl[k].s});
         cmp({"tbl ", tbl[k].s, " result"}, 32'(result), 32'(tbl[k].res));
         cmp({"tbl ", tbl[k].s, " result_valid"}, 32'(result_valid), 32'(tbl[k].rv));
         cmp({"tbl ", tbl[k].s, " ovf"}, 32'(ovf), 32'(tbl[k].ov));
         cmp({"tbl ", tbl[k].s, " err"}, 32'(err), 32'(tbl[k].er));
         cmp({"tbl ", tbl[k].s, " status"}, 32'(status), 32'(tbl[k].st));
      end

      // Operator drops result_valid at once; idle cycles hold everything.
      tick(1, 0, 8'h00);
      tick(0, 1, "2");
      cmp("seq2 rv after 2", 32'(result_valid), 1);
      tick(0, 1, "*");
      cmp("seq2 rv after *", 32'(result_valid), 0);
      cmp("seq2 result after *", 32'(result), 2);
      cmp("seq2 status after *", 32'(status), 2);
      tick(0, 0, "+");
      cmp("seq2 status idle", 32'(status), 2);
      tick(0, 1, "3");
      cmp("seq2 result after 3", 32'(result), 6);

      // Error from the second '+', result held, later digit ignored.
      tick(1, 0, 8'h00);
      tick(0, 1, "1");
      tick(0, 1, "+");
      tick(0, 1, "+");
      cmp("seq3 err", 32'(err), 1);
      cmp("seq3 status", 32'(status), 3);
      cmp("seq3 result", 32'(result), 1);
      tick(0, 1, "2");
      cmp("seq3 result after 2", 32'(result), 1);
      cmp("seq3 rv after 2", 32'(result_valid), 0);

      // clr coincides with '*': char discarded, fresh expression follows.
      tick(1, 0, 8'h00);
      tick(0, 1, "1");
      tick(0, 1, "+");
      tick(0, 1, "2");
      tick(1, 1, "*");
      cmp("seq5 result at clr", 32'(result), 0);
      cmp("seq5 status at clr", 32'(status), 0);
      tick(0, 1, "5");
      cmp("seq5 result", 32'(result), 5);
      cmp("seq5 err", 32'(err), 0);
      cmp("seq5 rv", 32'(result_valid), 1);

      // Random streams against the reference model, checked every cycle.
      tick(1, 0, 8'h00);
      for (int it = 0; it < 300; it++) begin
         tick(1, 0, 8'h00);
         check_model("rnd clr");
         n_expr = 0;
         len = $urandom_range(1, 14);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 99) < 3) begin
               tick(1, 1, "+");
               check_model("rnd midclr");
            end
            if ((q.size() == 0) || !is_digit(q[$]))
               ch = ($urandom_range(0, 99) < 92) ? byte'($urandom_range(48, 57))
                                                 : byte'($urandom_range(32, 126));
            else if ($urandom_range(0, 99) < 92)
               ch = $urandom_range(0, 1) ? "+" : "*";
            else
               ch = byte'($urandom_range(32, 126));
            tick(0, 1, ch);
            check_model("rnd");
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               tick(0, 0, byte'($urandom_range(0, 255)));
               check_model("rnd idle");
            end
            n_expr++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
